// File: rtl/draw_list_sequencer.sv
// draw_list_sequencer
// Walks NUM_LAYERS programmable draw layers in ascending order and, inside each
// valid layer, issues one draw request per item through a req/done handshake.
// Layer enables and item counts are captured when a frame starts, so the game
// logic may change them freely while a frame is being drawn.
//
// Ports:
//   clock, reset    system clock, asynchronous active-high reset
//   start, abort    begin a frame (IDLE only) / cancel the frame in progress
//   layer_enable    one include bit per layer
//   layer_count     packed per-layer item counts, ID_W+1 bits per layer
//   draw_req        request to the datapath, held until draw_done
//   draw_layer      layer of the current request
//   draw_item       item of the current request
//   draw_done       datapath finished the current item
//   busy            high whenever a frame is in progress
//   frame_done      one-cycle pulse on normal frame completion
//   frame_count     completed-frame counter, wraps
module draw_list_sequencer #(
  parameter int NUM_LAYERS = 8,
  parameter int ID_W       = 3,
  parameter int LAYER_W    = 3,
  parameter int FRAME_W    = 8
) (
  input  logic                           clock,
  input  logic                           reset,
  input  logic                           start,
  input  logic                           abort,
  input  logic [NUM_LAYERS-1:0]          layer_enable,
  input  logic [NUM_LAYERS*(ID_W+1)-1:0] layer_count,
  output logic                           draw_req,
  output logic [LAYER_W-1:0]             draw_layer,
  output logic [ID_W-1:0]                draw_item,
  input  logic                           draw_done,
  output logic                           busy,
  output logic                           frame_done,
  output logic [FRAME_W-1:0]             frame_count
);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_SCAN = 3'd1,
    S_REQ  = 3'd2,
    S_NEXT = 3'd3,
    S_DONE = 3'd4
  } state_t;

  localparam int CW = ID_W + 1;
  localparam logic [ID_W:0]      MAX_COUNT  = {1'b1, {ID_W{1'b0}}};
  localparam logic [LAYER_W-1:0] LAST_LAYER = LAYER_W'(NUM_LAYERS - 1);

  state_t                      state_q, state_d;
  logic [LAYER_W-1:0]          layer_q, layer_d;
  // One bit wider than draw_item so a full layer of 2^ID_W items never wraps.
  logic [ID_W:0]               item_q, item_d;
  logic [NUM_LAYERS-1:0]       enable_q, enable_d;
  logic [NUM_LAYERS*CW-1:0]    count_q, count_d;
  logic                        draw_req_q, draw_req_d;
  logic                        busy_q, busy_d;
  logic                        frame_done_q, frame_done_d;
  logic [FRAME_W-1:0]          frame_count_q, frame_count_d;

  logic [NUM_LAYERS*CW-1:0]    clamped_count_s;
  logic [ID_W:0]               cur_count_s;
  logic                        cur_enable_s;
  logic                        cur_valid_s;
  logic                        last_layer_s;
  logic                        more_items_s;

  // Clamp each incoming count to the layer capacity before it is snapshotted.
  always_comb begin
    clamped_count_s = {(NUM_LAYERS*CW){1'b0}};
    for (int l = 0; l < NUM_LAYERS; l++) begin
      clamped_count_s[l*CW +: CW] = (layer_count[l*CW +: CW] > MAX_COUNT) ?
                                    MAX_COUNT : layer_count[l*CW +: CW];
    end
  end

  // Select the snapshot enable/count of the layer currently being walked.
  always_comb begin
    cur_count_s  = {CW{1'b0}};
    cur_enable_s = 1'b0;
    for (int l = 0; l < NUM_LAYERS; l++) begin
      cur_count_s  = (layer_q == LAYER_W'(l)) ? count_q[l*CW +: CW] : cur_count_s;
      cur_enable_s = (layer_q == LAYER_W'(l)) ? enable_q[l] : cur_enable_s;
    end
    cur_valid_s  = cur_enable_s && (cur_count_s != {CW{1'b0}});
    last_layer_s = (layer_q == LAST_LAYER);
    more_items_s = ((item_q + CW'(1'b1)) < cur_count_s);
  end

  // Next-state, walk counters and registered-output values.
  always_comb begin
    state_d     = state_q;
    layer_d     = layer_q;
    item_d      = item_q;
    enable_d    = enable_q;
    count_d     = count_q;

    if (abort && (state_q != S_IDLE)) begin
      // Abort wins over draw_done and never completes the frame.
      state_d = S_IDLE;
      layer_d = {LAYER_W{1'b0}};
      item_d  = {CW{1'b0}};
    end else begin
      case (state_q)
        S_IDLE: begin
          if (start && !abort) begin
            state_d  = S_SCAN;
            layer_d  = {LAYER_W{1'b0}};
            item_d   = {CW{1'b0}};
            enable_d = layer_enable;
            count_d  = clamped_count_s;
          end else begin
            state_d = S_IDLE;
          end
        end
        S_SCAN: begin
          if (cur_valid_s) begin
            state_d = S_REQ;
          end else if (last_layer_s) begin
            state_d = S_DONE;
          end else begin
            layer_d = layer_q + LAYER_W'(1'b1);
          end
        end
        S_REQ: begin
          if (draw_done) begin
            state_d = S_NEXT;
          end else begin
            state_d = S_REQ;
          end
        end
        S_NEXT: begin
          if (more_items_s) begin
            item_d  = item_q + CW'(1'b1);
            state_d = S_REQ;
          end else begin
            item_d = {CW{1'b0}};
            if (last_layer_s) begin
              state_d = S_DONE;
            end else begin
              layer_d = layer_q + LAYER_W'(1'b1);
              state_d = S_SCAN;
            end
          end
        end
        S_DONE: begin
          state_d = S_IDLE;
        end
        default: begin
          state_d = S_IDLE;
        end
      endcase
    end

    // Outputs are derived from the next state so they register with it.
    draw_req_d    = (state_d == S_REQ);
    busy_d        = (state_d != S_IDLE);
    frame_done_d  = (state_d == S_DONE);
    frame_count_d = (state_d == S_DONE) ? (frame_count_q + FRAME_W'(1'b1)) : frame_count_q;
  end

  // State, snapshot and output registers.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q       <= S_IDLE;
      layer_q       <= {LAYER_W{1'b0}};
      item_q        <= {CW{1'b0}};
      enable_q      <= {NUM_LAYERS{1'b0}};
      count_q       <= {(NUM_LAYERS*CW){1'b0}};
      draw_req_q    <= 1'b0;
      busy_q        <= 1'b0;
      frame_done_q  <= 1'b0;
      frame_count_q <= {FRAME_W{1'b0}};
    end else begin
      state_q       <= state_d;
      layer_q       <= layer_d;
      item_q        <= item_d;
      enable_q      <= enable_d;
      count_q       <= count_d;
      draw_req_q    <= draw_req_d;
      busy_q        <= busy_d;
      frame_done_q  <= frame_done_d;
      frame_count_q <= frame_count_d;
    end
  end

  assign draw_req    = draw_req_q;
  assign draw_layer  = layer_q;
  assign draw_item   = item_q[ID_W-1:0];
  assign busy        = busy_q;
  assign frame_done  = frame_done_q;
  assign frame_count = frame_count_q;

endmodule

// File: tb/tb_draw_list_sequencer.sv
// tb_draw_list_sequencer
// Self-checking bench for draw_list_sequencer. A schedule model expands each
// accepted frame into its list of cycle slots (one scan slot per layer, a
// request slot plus a gap slot per item, a final done slot) and the main
// process compares the DUT outputs against the head of that schedule on every
// falling edge. Directed frames pin the model with hand-computed literals.
module tb_draw_list_sequencer;

  localparam int NL = 8;
  localparam int IW = 3;
  localparam int LW = 3;
  localparam int FW = 8;
  localparam int CW = IW + 1;

  localparam int K_SCAN = 0;
  localparam int K_REQ  = 1;
  localparam int K_NEXT = 2;
  localparam int K_DONE = 3;

  typedef struct {
    int kind;
    int layer;
    int item;
  } slot_t;

  logic              clock = 1'b0;
  logic              reset = 1'b1;
  logic              start = 1'b0;
  logic              abort = 1'b0;
  logic [NL-1:0]     layer_enable = '0;
  logic [NL*CW-1:0]  layer_count = '0;
  logic              draw_req;
  logic [LW-1:0]     draw_layer;
  logic [IW-1:0]     draw_item;
  logic              draw_done;
  logic              busy;
  logic              frame_done;
  logic [FW-1:0]     frame_count;

  logic              done_auto = 1'b0;
  logic              manual_done = 1'b0;
  int                done_mode = 1;   // 0 random, 1 immediate, 2 manual

  int                n_checks = 0;
  int                n_fail = 0;
  int                fd_seen = 0;
  slot_t             sched[$];
  int                m_fc = 0;
  int                obs_l[$];
  int                obs_i[$];
  int                cnt_cfg [NL];
  int                exp_a_l [5] = '{0, 0, 0, 2, 2};
  int                exp_a_i [5] = '{0, 1, 2, 0, 1};

  draw_list_sequencer #(
    .NUM_LAYERS(NL),
    .ID_W(IW),
    .LAYER_W(LW),
    .FRAME_W(FW)
  ) dut (
    .clock(clock),
    .reset(reset),
    .start(start),
    .abort(abort),
    .layer_enable(layer_enable),
    .layer_count(layer_count),
    .draw_req(draw_req),
    .draw_layer(draw_layer),
    .draw_item(draw_item),
    .draw_done(draw_done),
    .busy(busy),
    .frame_done(frame_done),
    .frame_count(frame_count)
  );

  always #5 clock = ~clock;

  assign draw_done = (done_mode == 2) ? manual_done : done_auto;

  function automatic slot_t mk(input int k, input int l, input int i);
    slot_t s;
    s.kind = k;
    s.layer = l;
    s.item = i;
    return s;
  endfunction

  // Expand a snapshot into the frame's slot schedule.
  function automatic void build(input logic [NL-1:0] en, input logic [NL*CW-1:0] cnt);
    int c;
    for (int l = 0; l < NL; l++) begin
      sched.push_back(mk(K_SCAN, l, 0));
      c = int'(cnt[l*CW +: CW]);
      if (c > (1 << IW)) c = 1 << IW;
      if (en[l]) begin
        for (int i = 0; i < c; i++) begin
          sched.push_back(mk(K_REQ, l, i));
          sched.push_back(mk(K_NEXT, l, i));
        end
      end
    end
    sched.push_back(mk(K_DONE, 0, 0));
  endfunction

  function automatic logic [NL*CW-1:0] pack_counts(input int c [NL]);
    logic [NL*CW-1:0] v;
    v = '0;
    for (int l = 0; l < NL; l++) v[l*CW +: CW] = CW'(c[l]);
    return v;
  endfunction

  // Datapath stand-in: answers requests immediately or after random delays.
  always @(negedge clock) begin
    if (done_mode == 1) done_auto <= draw_req;
    else done_auto <= draw_req ? ($urandom_range(0, 2) == 0) : ($urandom_range(0, 3) == 0);
  end

  // Schedule model: advances one slot per clock, request slots wait for done.
  always @(posedge clock or posedge reset) begin
    if (reset) begin
      sched.delete();
      m_fc <= 0;
    end else if (sched.size() == 0) begin
      if (start && !abort) build(layer_enable, layer_count);
    end else if (abort) begin
      sched.delete();
    end else if (sched[0].kind != K_REQ || draw_done) begin
      void'(sched.pop_front());
      if (sched.size() > 0 && sched[0].kind == K_DONE) m_fc <= (m_fc + 1) % 256;
    end
  end

  // Record every accepted handshake.
  always @(posedge clock) begin
    if (!reset && draw_req && draw_done) begin
      obs_l.push_back(int'(draw_layer));
      obs_i.push_back(int'(draw_item));
    end
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual %0d required %0d", name, act, exp);
    end
  endtask

  // Advance one cycle and compare DUT outputs against the schedule head.
  task automatic tick();
    logic exp_req;
    @(negedge clock);
    if (!reset) begin
      exp_req = (sched.size() > 0) && (sched[0].kind == K_REQ);
      check("busy", busy, sched.size() > 0);
      check("draw_req", draw_req, exp_req);
      check("frame_done", frame_done, (sched.size() > 0) && (sched[0].kind == K_DONE));
      check("frame_count", frame_count, m_fc);
      if (exp_req) begin
        check("draw_layer", draw_layer, sched[0].layer);
        check("draw_item", draw_item, sched[0].item);
      end
    end
    if (frame_done) fd_seen++;
  endtask

  task automatic randomize_cfg();
    for (int l = 0; l < NL; l++) cnt_cfg[l] = $urandom_range(0, 9);
    layer_enable = NL'($urandom);
    layer_count = pack_counts(cnt_cfg);
  endtask

  // Pulse start and walk the frame; mode 1 adds start pulses, mode 2 also churns the config.
  task automatic run_frame(input int budget, input int mode, output int busy_cyc, output int done_at);
    int k;
    busy_cyc = 0;
    done_at = -1;
    start = 1'b1;
    tick();
    start = 1'b0;
    for (k = 1; k <= budget; k++) begin
      if (busy) busy_cyc++;
      if (frame_done && done_at < 0) done_at = k;
      if (!busy) break;
      if (mode >= 1) start = ($urandom_range(0, 3) == 0);
      if (mode == 2) randomize_cfg();
      tick();
    end
    start = 1'b0;
    check("frame_in_budget", k <= budget, 1'b1);
  endtask

  task automatic wait_req(input int l, input int i, input int budget);
    int k = 0;
    while (!(draw_req && draw_layer == LW'(l) && draw_item == IW'(i)) && k < budget) begin
      tick();
      k++;
    end
    check("wait_req_in_budget", k < budget, 1'b1);
  endtask

  task automatic check_list_a(input string tag);
    check({tag, "_n"}, obs_l.size(), 5);
    for (int i = 0; i < 5 && i < obs_l.size(); i++) begin
      check({tag, "_layer"}, obs_l[i], exp_a_l[i]);
      check({tag, "_item"}, obs_i[i], exp_a_i[i]);
    end
  endtask

  task automatic set_cfg_a();
    cnt_cfg = '{3, 0, 2, 0, 0, 0, 0, 0};
    layer_enable = 8'b0000_0101;
    layer_count = pack_counts(cnt_cfg);
  endtask

  initial begin
    int bc;
    int da;
    int fd0;

    // Reset state
    tick();
    tick();
    check("rst_draw_req", draw_req, 1'b0);
    check("rst_busy", busy, 1'b0);
    check("rst_frame_done", frame_done, 1'b0);
    check("rst_frame_count", frame_count, 0);
    check("rst_draw_layer", draw_layer, 0);
    check("rst_draw_item", draw_item, 0);
    reset = 1'b0;
    tick();

    // Two layers, immediate done: 8 scans + 5*(req+gap) + done = 19 busy cycles
    set_cfg_a();
    obs_l.delete(); obs_i.delete();
    fd0 = fd_seen;
    run_frame(100, 0, bc, da);
    check_list_a("a_seq");
    check("a_busy_cycles", bc, 19);
    check("a_done_at", da, 19);
    check("a_frame_dones", fd_seen - fd0, 1);
    check("a_frame_count", frame_count, 1);

    // Empty frame: 8 scans then done
    cnt_cfg = '{0, 0, 0, 0, 0, 0, 0, 0};
    layer_enable = 8'hFF;
    layer_count = pack_counts(cnt_cfg);
    obs_l.delete(); obs_i.delete();
    run_frame(50, 0, bc, da);
    check("empty_done_at", da, 9);
    check("empty_busy_cycles", bc, 9);
    check("empty_reqs", obs_l.size(), 0);
    check("empty_frame_count", frame_count, 2);

    // Full layer 7 with count 8, then count 9 clamped to 8
    for (int pass = 0; pass < 2; pass++) begin
      cnt_cfg = '{0, 0, 0, 0, 0, 0, 0, 8 + pass};
      layer_enable = 8'h80;
      layer_count = pack_counts(cnt_cfg);
      obs_l.delete(); obs_i.delete();
      run_frame(100, 0, bc, da);
      check("full_n", obs_l.size(), 8);
      for (int i = 0; i < 8 && i < obs_l.size(); i++) begin
        check("full_layer", obs_l[i], 7);
        check("full_item", obs_i[i], i);
      end
      check("full_busy_cycles", bc, 25);
      check("full_frame_count", frame_count, 3 + pass);
    end

    // Abort together with draw_done on (1,0)
    cnt_cfg = '{0, 2, 0, 0, 0, 0, 0, 0};
    layer_enable = 8'b0000_0010;
    layer_count = pack_counts(cnt_cfg);
    done_mode = 2;
    manual_done = 1'b0;
    start = 1'b1;
    tick();
    start = 1'b0;
    wait_req(1, 0, 20);
    tick();
    tick();
    check("abort_req_held", draw_req, 1'b1);
    fd0 = fd_seen;
    abort = 1'b1;
    manual_done = 1'b1;
    tick();
    abort = 1'b0;
    manual_done = 1'b0;
    check("abort_draw_req", draw_req, 1'b0);
    check("abort_busy", busy, 1'b0);
    check("abort_frame_count", frame_count, 4);
    repeat (3) tick();
    check("abort_no_frame_done", fd_seen - fd0, 0);
    done_mode = 1;

    // Start pulses during a frame are ignored
    set_cfg_a();
    obs_l.delete(); obs_i.delete();
    run_frame(100, 1, bc, da);
    check_list_a("restart_seq");
    check("restart_busy_cycles", bc, 19);
    check("restart_frame_count", frame_count, 5);

    // Reset while requesting (2,1)
    start = 1'b1;
    tick();
    start = 1'b0;
    wait_req(2, 1, 40);
    #2 reset = 1'b1;
    #1;
    check("mid_rst_draw_req", draw_req, 1'b0);
    check("mid_rst_busy", busy, 1'b0);
    check("mid_rst_draw_layer", draw_layer, 0);
    check("mid_rst_draw_item", draw_item, 0);
    check("mid_rst_frame_count", frame_count, 0);
    tick();
    reset = 1'b0;
    tick();
    obs_l.delete(); obs_i.delete();
    run_frame(100, 0, bc, da);
    check_list_a("post_rst_seq");
    check("post_rst_frame_count", frame_count, 1);

    // Random traffic with aborts, start/abort collisions and churning inputs
    done_mode = 0;
    for (int c = 0; c < 3000; c++) begin
      start = ($urandom_range(0, 5) == 0);
      abort = ($urandom_range(0, 29) == 0);
      randomize_cfg();
      tick();
    end
    start = 1'b0;
    abort = 1'b0;

    // 256 random frames with inputs changing mid-frame; counter wraps to 0
    reset = 1'b1;
    tick();
    reset = 1'b0;
    tick();
    fd0 = fd_seen;
    for (int f = 0; f < 256; f++) begin
      randomize_cfg();
      run_frame(1500, 2, bc, da);
      if (f == 254) check("wrap_fc_255", frame_count, 255);
    end
    check("wrap_frame_count", frame_count, 0);
    check("wrap_frame_dones", fd_seen - fd0, 256);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
